res_arbiter: RTL
================

RES_ARBITER -- requirements
Module: res_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the width of each requester payload and of data_o.
REQ-002 Parameter TIMEOUT, default 16, SHALL set the maximum number of WAIT cycles before a grant is revoked; legal range 2..255.
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates occur on the rising edge.
REQ-004 rst_i  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 req_i  input  4  SHALL carry the per-requester request bits; bit k is requester k.
REQ-006 data0_i..data3_i  input  DATA_W each  SHALL carry the requester payloads.
REQ-007 done_i  input  1  SHALL be the shared resource's transaction-complete strobe.
REQ-008 gnt_o  output  4  SHALL be the one-hot registered grant, or all-zero when no grant is active.
REQ-009 sel_o  output  2  SHALL be the binary index of the granted requester and SHALL drive the payload steering.
REQ-010 data_o  output  DATA_W  SHALL be the payload of requester sel_o, combinational from sel_o.
REQ-011 valid_o  output  1  SHALL pulse for exactly one cycle to issue the granted payload to the resource.
REQ-012 busy_o  output  1  SHALL be high in ISSUE and WAIT states.
REQ-013 err_o  output  1  SHALL pulse for one cycle when a grant is revoked by timeout.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ISSUE, WAIT.
REQ-015 IDLE with req_i != 0 SHALL transition to ISSUE, with gnt_o/sel_o latched at that edge for the winning requester.
REQ-016 The winner SHALL be the first set req_i bit, searching upward modulo 4 from the priority pointer ptr (2 bits).
REQ-017 ISSUE SHALL last one cycle with valid_o=1, then go to WAIT; if done_i=1 in ISSUE, it SHALL go directly to IDLE.
REQ-018 WAIT SHALL remain until done_i=1 or timeout, then go to IDLE; gnt_o SHALL clear and ptr SHALL become sel_o+1 (mod 4) at that edge.
REQ-019 Request-to-grant latency SHALL be one cycle from an IDLE-cycle req_i; minimum transaction is 2 cycles (ISSUE, IDLE).
REQ-020 A timeout counter SHALL clear on entry to ISSUE, increment each WAIT cycle, and on reaching TIMEOUT-1 without done_i, force IDLE and pulse err_o.
REQ-021 When done_i and the timeout condition coincide, done_i SHALL win; err_o SHALL remain 0.
REQ-022 done_i outside ISSUE/WAIT SHALL be ignored.
REQ-023 Changes of req_i during ISSUE/WAIT SHALL not affect gnt_o/sel_o; a granted requester dropping req_i SHALL not end the grant.
REQ-024 sel_o SHALL hold its last value in IDLE; gnt_o SHALL be 0 in IDLE.

Reset
REQ-025 rst_i=1 at a clock edge SHALL force: state IDLE, ptr 0, counter 0, gnt_o 0, sel_o 0, valid_o 0, busy_o 0, err_o 0.
REQ-026 Reset asserted mid-transaction SHALL abandon the grant with no err_o pulse; the first post-reset arbitration SHALL start from ptr=0.

Structure
REQ-027 State encodings (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2) and the default DATA_W/TIMEOUT values SHALL live in the shared package.
REQ-028 Payload steering SHALL instantiate the existing MUX_4to1 (size=DATA_W, select_i=sel_o); all other logic SHALL be local to res_arbiter.

Verification
REQ-029 After reset, req_i=4'b0101 held: grants in order 0,2,0,2 with done_i one cycle after each valid_o; sel_o=0,2,0,2.
REQ-030 req_i=4'b1000 in IDLE at cycle N: gnt_o=4'b1000, valid_o=1 at N+1; data_o=data3_i; done_i at N+3 -> gnt_o=0 at N+4.
REQ-031 TIMEOUT=4, single request, done_i never asserted: err_o pulses once, 4 cycles after ISSUE; ptr advances; no second err_o.
REQ-032 done_i and timeout in the same cycle: IDLE next cycle, err_o=0.
REQ-033 done_i=1 during ISSUE: IDLE next cycle, WAIT never entered, busy_o high for one cycle only.
REQ-034 rst_i pulsed during WAIT with req_i=4'b1111: all outputs 0 the next cycle, then grant to requester 0.

Source files
------------

// File: rtl/res_arbiter_pkg.sv
// rtl/res_arbiter_pkg.sv - shared types, defaults and round-robin helper for res_arbiter
//
// Purpose : FSM state encoding, default parameter values and the
//           round-robin winner search used by res_arbiter.
// Ports   : none (package)
package res_arbiter_pkg;

   localparam int DATA_W_DEF  = 32;
   localparam int TIMEOUT_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   // First set request bit, searching upward (mod 4) starting at ptr.
   // Returns ptr when no bit is set; callers only use it with req != 0.
   function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
      logic [1:0] idx;
      logic       found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idx = ptr + 2'(i);
         if (!found && req[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/res_arbiter_if.sv
// rtl/res_arbiter_if.sv - request/grant/payload bundle between requesters and res_arbiter
//
// Purpose : groups the arbiter's request, payload, grant and status signals.
// Ports   : master modport - requester/resource side (drives req_i, data*_i, done_i)
//           slave modport  - arbiter side (drives gnt_o, sel_o, data_o, valid_o, busy_o, err_o)
interface res_arbiter_if import res_arbiter_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF
) ();

   logic [3:0]        req_i;
   logic [DATA_W-1:0] data0_i;
   logic [DATA_W-1:0] data1_i;
   logic [DATA_W-1:0] data2_i;
   logic [DATA_W-1:0] data3_i;
   logic              done_i;
   logic [3:0]        gnt_o;
   logic [1:0]        sel_o;
   logic [DATA_W-1:0] data_o;
   logic              valid_o;
   logic              busy_o;
   logic              err_o;

   modport master (
      output req_i, data0_i, data1_i, data2_i, data3_i, done_i,
      input  gnt_o, sel_o, data_o, valid_o, busy_o, err_o
   );

   modport slave (
      input  req_i, data0_i, data1_i, data2_i, data3_i, done_i,
      output gnt_o, sel_o, data_o, valid_o, busy_o, err_o
   );

endinterface

// File: rtl/MUX_4to1.sv
// rtl/MUX_4to1.sv - 4-input payload multiplexer
//
// Purpose : combinational 4:1 selector of size-bit words.
// Ports   : select_i        - 2-bit binary select
//           data0_i..data3_i - candidate words
//           data_o          - selected word
module MUX_4to1 #(
   parameter int size = 32
) (
   input  logic [1:0]      select_i,
   input  logic [size-1:0] data0_i,
   input  logic [size-1:0] data1_i,
   input  logic [size-1:0] data2_i,
   input  logic [size-1:0] data3_i,
   output logic [size-1:0] data_o
);

   always_comb begin
      data_o = data0_i;
      case (select_i)
         2'd0:    data_o = data0_i;
         2'd1:    data_o = data1_i;
         2'd2:    data_o = data2_i;
         default: data_o = data3_i;
      endcase
   end

endmodule

// File: rtl/res_arbiter.sv
// rtl/res_arbiter.sv - round-robin arbiter for a shared resource with issue/wait/timeout FSM
//
// Purpose : grants one of four requesters, issues its payload for one cycle,
//           waits for done_i or a timeout, then rotates priority.
// Ports   : clk_i - clock, rising edge
//           rst_i - synchronous active-high reset
//           bus   - res_arbiter_if.slave (req_i, data0_i..data3_i, done_i in;
//                   gnt_o, sel_o, data_o, valid_o, busy_o, err_o out)
module res_arbiter import res_arbiter_pkg::*; #(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic          clk_i,
   input  logic          rst_i,
   res_arbiter_if.slave  bus
);

   // The counter reads 0 in the first WAIT cycle, so the last permitted WAIT
   // cycle is the one where it shows TIMEOUT-2; leaving from it lands the
   // registered err_o in the cycle where the counter would have read TIMEOUT-1.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 2);

   state_t     state;
   state_t     state_nxt;
   logic [1:0] ptr;
   logic [1:0] sel;
   logic [3:0] gnt;
   logic [7:0] cnt;
   logic       err;
   logic       start;
   logic       finish;
   logic       timeout_hit;
   logic [1:0] win;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      start       = 1'b0;
      finish      = 1'b0;
      timeout_hit = 1'b0;
      win         = rr_pick(bus.req_i, ptr);
      case (state)
         IDLE: begin
            if (bus.req_i != 4'b0000) begin
               state_nxt = ISSUE;
               start     = 1'b1;
            end
         end
         ISSUE: begin
            if (bus.done_i) begin
               state_nxt = IDLE;
               finish    = 1'b1;
            end else begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            // done_i is checked first so it wins over a coincident timeout.
            if (bus.done_i) begin
               state_nxt = IDLE;
               finish    = 1'b1;
            end else if (cnt == CNT_LAST) begin
               state_nxt   = IDLE;
               finish      = 1'b1;
               timeout_hit = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Grant, select, priority pointer and timeout counter.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr <= 2'd0;
         sel <= 2'd0;
         gnt <= 4'b0000;
         cnt <= 8'd0;
         err <= 1'b0;
      end else begin
         err <= timeout_hit;
         if (start) begin
            sel <= win;
            gnt <= 4'b0001 << win;
            cnt <= 8'd0;
         end
         if (state == WAIT) begin
            cnt <= cnt + 8'd1;
         end
         // sel is left untouched so it holds through IDLE.
         if (finish) begin
            gnt <= 4'b0000;
            ptr <= sel + 2'd1;
         end
      end
   end

   assign bus.gnt_o   = gnt;
   assign bus.sel_o   = sel;
   assign bus.valid_o = (state == ISSUE);
   assign bus.busy_o  = (state != IDLE);
   assign bus.err_o   = err;

   MUX_4to1 #(
      .size (DATA_W)
   ) u_mux (
      .select_i (sel),
      .data0_i  (bus.data0_i),
      .data1_i  (bus.data1_i),
      .data2_i  (bus.data2_i),
      .data3_i  (bus.data3_i),
      .data_o   (bus.data_o)
   );

endmodule
